// File: rtl/text_pkg.sv
// text_pkg: shared control codes, FSM encoding and width helper for the text buffer
package text_pkg;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/dp_ram.sv
// dp_ram: simple dual-port RAM, one sync read and one write port; read returns the old word on a collision
module dp_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/text_buffer.sv
// text_buffer: COLS x ROWS character buffer with pixel-addressed read port and terminal-style write port
// Scrolling rotates a ring top-row pointer; a background engine blanks the recycled row.
module text_buffer
    import text_pkg::*;
#(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int DATA_W      = 8,
    parameter int ZOOM        = 0,
    parameter int FONT_W_LOG2 = 3,
    parameter int FONT_H_LOG2 = 4,
    parameter int PX_W        = 10
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PX_W-1:0]          px_x,
    input  logic [PX_W-1:0]          px_y,
    output logic [DATA_W-1:0]        dout,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_char,
    output logic [clog2(COLS)-1:0]   cur_col,
    output logic [clog2(ROWS)-1:0]   cur_row,
    output logic                     busy
);
    localparam int COL_W  = clog2(COLS);
    localparam int ROW_W  = clog2(ROWS);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   ROWS_X   = (ROW_W + 1)'(ROWS);
    localparam logic [DATA_W-1:0] SPACE   = DATA_W'(CH_SPACE);

    function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] t);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, t};
        return s >= ROWS_X ? ROW_W'(s - ROWS_X) : s[ROW_W-1:0];
    endfunction

    state_t state, state_n;
    logic [COL_W-1:0] col_n, clr_cnt, cnt_n;
    logic [ROW_W-1:0] row_n, top, top_n, clr_row, crow_n;
    logic we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata, rdata;
    logic [PX_W-1:0] px_col, px_row;
    logic rd_in, oob_q;
    logic is_nl, is_ff, is_bs, is_pr;

    assign px_col = px_x >> (FONT_W_LOG2 + ZOOM);
    assign px_row = px_y >> (FONT_H_LOG2 + ZOOM);
    assign rd_in  = (px_col < PX_W'(COLS)) && (px_row < PX_W'(ROWS));
    assign raddr  = {phys(px_row[ROW_W-1:0], top), px_col[COL_W-1:0]};
    assign dout   = oob_q ? SPACE : rdata;

    assign wr_ready = (state == IDLE);
    assign busy     = ~wr_ready;
    assign is_nl    = wr_char == DATA_W'(CH_NL);
    assign is_ff    = wr_char == DATA_W'(CH_FF);
    assign is_bs    = wr_char == DATA_W'(CH_BS);
    assign is_pr    = !(is_nl || is_ff || is_bs);

    always_comb begin
        state_n = state;
        col_n   = cur_col;
        row_n   = cur_row;
        top_n   = top;
        cnt_n   = clr_cnt;
        crow_n  = clr_row;
        we      = 1'b0;
        waddr   = '0;
        wdata   = SPACE;
        case (state)
            IDLE: if (wr_valid) begin
                if (is_pr) begin
                    we    = 1'b1;
                    waddr = {phys(cur_row, top), cur_col};
                    wdata = wr_char;
                    col_n = cur_col + 1'b1;
                end
                // a printable in the last column wraps exactly like a newline
                if (is_nl || (is_pr && cur_col == LAST_COL)) begin
                    col_n = '0;
                    if (cur_row < LAST_ROW) row_n = cur_row + 1'b1;
                    else begin
                        top_n   = top == LAST_ROW ? '0 : top + 1'b1;
                        cnt_n   = '0;
                        state_n = CLR_ROW;
                    end
                end
                if (is_bs && cur_col != '0) begin
                    col_n = cur_col - 1'b1;
                    we    = 1'b1;
                    waddr = {phys(cur_row, top), col_n};
                end
                if (is_ff) begin
                    cnt_n   = '0;
                    crow_n  = '0;
                    state_n = CLR_ALL;
                end
            end
            CLR_ROW: begin
                we      = 1'b1;
                waddr   = {top == '0 ? LAST_ROW : top - 1'b1, clr_cnt};
                cnt_n   = clr_cnt == LAST_COL ? '0 : clr_cnt + 1'b1;
                state_n = clr_cnt == LAST_COL ? IDLE : CLR_ROW;
            end
            default: begin
                we    = 1'b1;
                waddr = {clr_row, clr_cnt};
                cnt_n = clr_cnt == LAST_COL ? '0 : clr_cnt + 1'b1;
                if (clr_cnt == LAST_COL) begin
                    crow_n = clr_row == LAST_ROW ? '0 : clr_row + 1'b1;
                    if (clr_row == LAST_ROW) begin
                        col_n   = '0;
                        row_n   = '0;
                        top_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= CLR_ALL;
            cur_col <= '0;
            cur_row <= '0;
            top     <= '0;
            clr_cnt <= '0;
            clr_row <= '0;
            oob_q   <= 1'b1;
        end else begin
            state   <= state_n;
            cur_col <= col_n;
            cur_row <= row_n;
            top     <= top_n;
            clr_cnt <= cnt_n;
            clr_row <= crow_n;
            oob_q   <= !rd_in;
        end
    end

    dp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule
